// File: rtl/fetch_pc_unit.sv
// Program counter and IF/ID pipeline register with branch/jump redirect, stall hold,
// a post-branch shadow window that ignores wrong-path requests, and saturating event counters.
module fetch_pc_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BR_SHADOW = 2,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Stall,
    input  logic [31:0]       InstrIn,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       IFID_Instr,
    output logic [ADDR_W-1:0] IFID_PCPlus4,
    output logic              IFID_Valid,
    output logic              FlushID,
    output logic [CNT_W-1:0]  TakenCount,
    output logic [CNT_W-1:0]  StallCount
);

    localparam int unsigned SH_W = (BR_SHADOW < 1) ? 1 : $clog2(BR_SHADOW + 1);
    localparam logic [SH_W-1:0] SHADOW_INIT = SH_W'(BR_SHADOW);

    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SH_W-1:0]   shadow_q, shadow_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pcp4_q, pcp4_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  taken_q, taken_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_adv;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcp4_d    = pcp4_q;
        valid_d   = valid_q;
        flush_d   = 1'b0;
        taken_d   = taken_q;
        stall_d   = stall_q;
        fetch_adv = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (BranchTaken) begin
                    pc_d     = {BranchTarget[ADDR_W-1:2], 2'b00};
                    valid_d  = 1'b0;
                    instr_d  = '0;
                    flush_d  = 1'b1;
                    shadow_d = SHADOW_INIT;
                    state_d  = (BR_SHADOW == 0) ? ST_RUN : ST_REDIRECT;
                    if (!(&taken_q)) begin
                        taken_d = taken_q + CNT_W'(1);
                    end
                end else if (Jump) begin
                    pc_d    = {JumpTarget[ADDR_W-1:2], 2'b00};
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (Stall) begin
                    if (!(&stall_q)) begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                end else begin
                    fetch_adv = 1'b1;
                end
            end
            ST_REDIRECT: begin
                // Requests here belong to squashed wrong-path instructions.
                fetch_adv = 1'b1;
                shadow_d  = shadow_q - SH_W'(1);
                if (shadow_q <= SH_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (fetch_adv) begin
            pc_d    = pc_plus4;
            instr_d = InstrIn;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_BOOT;
            shadow_q <= '0;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pcp4_q   <= '0;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
            taken_q  <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
            flush_q  <= flush_d;
            taken_q  <= taken_d;
            stall_q  <= stall_d;
        end
    end

    assign PC           = pc_q;
    assign IFID_Instr   = instr_q;
    assign IFID_PCPlus4 = pcp4_q;
    assign IFID_Valid   = valid_q;
    assign FlushID      = flush_q;
    assign TakenCount   = taken_q;
    assign StallCount   = stall_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus a randomized run against a
// behavioural model; a second instance with 2-bit counters checks saturation.
module tb_fetch_pc_unit;

    logic        Clk;
    logic        Rst_n;
    logic        br, j, st;
    logic [31:0] bt, jt, instr;

    logic [31:0] pc, ifid_instr, ifid_pcp4;
    logic        ifid_valid, flush;
    logic [15:0] taken, stall;

    logic [31:0] s_pc, s_instr, s_pcp4;
    logic        s_valid, s_flush;
    logic [1:0]  s_taken, s_stall;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pcp4;
    bit          m_valid, m_flush, m_boot;
    int          m_shadow, m_taken, m_stall;

    fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h0), .BR_SHADOW(2), .CNT_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .BranchTaken(br), .BranchTarget(bt), .Jump(j),
        .JumpTarget(jt), .Stall(st), .InstrIn(instr), .PC(pc), .IFID_Instr(ifid_instr),
        .IFID_PCPlus4(ifid_pcp4), .IFID_Valid(ifid_valid), .FlushID(flush),
        .TakenCount(taken), .StallCount(stall)
    );

    fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h0), .BR_SHADOW(2), .CNT_W(2)) dut_small (
        .Clk(Clk), .Rst_n(Rst_n), .BranchTaken(br), .BranchTarget(bt), .Jump(j),
        .JumpTarget(jt), .Stall(st), .InstrIn(instr), .PC(s_pc), .IFID_Instr(s_instr),
        .IFID_PCPlus4(s_pcp4), .IFID_Valid(s_valid), .FlushID(s_flush),
        .TakenCount(s_taken), .StallCount(s_stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
        m_valid = 0; m_flush = 0; m_boot = 1;
        m_shadow = 0; m_taken = 0; m_stall = 0;
    endtask

    task automatic model_fetch();
        m_instr = instr;
        m_pcp4  = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1;
    endtask

    task automatic model_step();
        m_flush = 0;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_shadow > 0) begin
            model_fetch();
            m_shadow--;
        end else if (br) begin
            m_pc = bt & ~32'd3; m_valid = 0; m_instr = 32'h0; m_flush = 1;
            m_taken++; m_shadow = 2;
        end else if (j) begin
            m_pc = jt & ~32'd3; m_valid = 0; m_instr = 32'h0;
        end else if (st) begin
            m_stall++;
        end else begin
            model_fetch();
        end
    endtask

    task automatic set_in(input bit b, input logic [31:0] btv, input bit jv,
                          input logic [31:0] jtv, input bit s);
        br = b; bt = btv; j = jv; jt = jtv; st = s; instr = $urandom;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0 || flush !== 1'b0)
            $display("FAIL rst_flags: got valid=%b flush=%b want 0 0", ifid_valid, flush);
        else n_pass++;
        n_total++; if (ifid_instr !== 32'h0 || ifid_pcp4 !== 32'h0)
            $display("FAIL rst_ifid: got %h %h want 0 0", ifid_instr, ifid_pcp4);
        else n_pass++;
        n_total++; if (taken !== 16'h0 || stall !== 16'h0)
            $display("FAIL rst_cnt: got %0d %0d want 0 0", taken, stall);
        else n_pass++;
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_boot_fetch();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 0, 0, 0);
            tick();
            n_total++; if (pc !== exp_pc[k])
                $display("FAIL boot_pc[%0d]: got %h want %h", k, pc, exp_pc[k]);
            else n_pass++;
            n_total++; if (ifid_valid !== (k > 0))
                $display("FAIL boot_valid[%0d]: got %b want %b", k, ifid_valid, k > 0);
            else n_pass++;
        end
        n_total++; if (ifid_instr !== m_instr || ifid_pcp4 !== 32'hC)
            $display("FAIL boot_ifid: got %h %h want %h c", ifid_instr, ifid_pcp4, m_instr);
        else n_pass++;
    endtask

    task automatic test_branch();
        set_in(0, 0, 0, 0, 0);
        tick();
        n_total++; if (pc !== 32'h10) $display("FAIL br_pre_pc: got %h want 10", pc); else n_pass++;
        set_in(1, 32'h40, 0, 0, 0);
        tick();
        n_total++; if (pc !== 32'h40) $display("FAIL br_pc: got %h want 40", pc); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0 || flush !== 1'b1 || ifid_instr !== 32'h0)
            $display("FAIL br_flags: got v=%b f=%b i=%h want 0 1 0", ifid_valid, flush, ifid_instr);
        else n_pass++;
        n_total++; if (taken !== 16'd1) $display("FAIL br_cnt: got %0d want 1", taken); else n_pass++;
    endtask

    task automatic test_shadow();
        logic [31:0] exp_pc [2];
        exp_pc[0] = 32'h44; exp_pc[1] = 32'h48;
        for (int k = 0; k < 2; k++) begin
            set_in(1, 32'h80, 1, 32'h300, 1);
            tick();
            n_total++; if (pc !== exp_pc[k])
                $display("FAIL sh_pc[%0d]: got %h want %h", k, pc, exp_pc[k]);
            else n_pass++;
            n_total++; if (taken !== 16'd1 || stall !== 16'd0 || flush !== 1'b0)
                $display("FAIL sh_cnt[%0d]: got t=%0d s=%0d f=%b want 1 0 0", k, taken, stall, flush);
            else n_pass++;
        end
        n_total++; if (ifid_valid !== 1'b1 || ifid_pcp4 !== 32'h48)
            $display("FAIL sh_ifid: got v=%b p4=%h want 1 48", ifid_valid, ifid_pcp4);
        else n_pass++;
        set_in(0, 0, 0, 0, 0);
        tick();
        n_total++; if (pc !== 32'h4C) $display("FAIL sh_exit_pc: got %h want 4c", pc); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] hold_instr, hold_pcp4;
        logic        hold_valid;
        set_in(0, 0, 1, 32'h20, 0);
        tick();
        n_total++; if (pc !== 32'h20) $display("FAIL st_pre_pc: got %h want 20", pc); else n_pass++;
        set_in(0, 0, 0, 0, 0);
        tick();
        hold_instr = m_instr; hold_pcp4 = m_pcp4; hold_valid = m_valid;
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 1);
            tick();
            n_total++; if (pc !== 32'h24 || ifid_instr !== hold_instr ||
                           ifid_pcp4 !== hold_pcp4 || ifid_valid !== hold_valid)
                $display("FAIL st_hold[%0d]: got pc=%h i=%h p4=%h v=%b want 24 %h %h %b",
                         k, pc, ifid_instr, ifid_pcp4, ifid_valid, hold_instr, hold_pcp4, hold_valid);
            else n_pass++;
        end
        n_total++; if (stall !== 16'd3) $display("FAIL st_cnt: got %0d want 3", stall); else n_pass++;
        set_in(1, 32'h60, 0, 0, 1);
        tick();
        n_total++; if (pc !== 32'h60 || stall !== 16'd3 || taken !== 16'd2 || flush !== 1'b1)
            $display("FAIL st_br: got pc=%h s=%0d t=%0d f=%b want 60 3 2 1", pc, stall, taken, flush);
        else n_pass++;
        set_in(0, 0, 0, 0, 0); tick(); tick();
    endtask

    task automatic test_jump();
        set_in(0, 0, 1, 32'h103, 0);
        tick();
        n_total++; if (pc !== 32'h100 || ifid_valid !== 1'b0 || flush !== 1'b0)
            $display("FAIL jmp: got pc=%h v=%b f=%b want 100 0 0", pc, ifid_valid, flush);
        else n_pass++;
        set_in(1, 32'h200, 1, 32'h500, 0);
        tick();
        n_total++; if (pc !== 32'h200 || flush !== 1'b1 || taken !== 16'd3)
            $display("FAIL jmp_br: got pc=%h f=%b t=%0d want 200 1 3", pc, flush, taken);
        else n_pass++;
        set_in(0, 0, 0, 0, 0); tick(); tick();
        set_in(0, 0, 1, 32'hFFFF_FFFE, 0);
        tick();
        n_total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL jmp_top: got %h want fffffffc", pc);
        else n_pass++;
        set_in(0, 0, 0, 0, 0);
        tick();
        n_total++; if (pc !== 32'h0 || ifid_pcp4 !== 32'h0 || ifid_valid !== 1'b1)
            $display("FAIL wrap: got pc=%h p4=%h v=%b want 0 0 1", pc, ifid_pcp4, ifid_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_redirect();
        set_in(1, 32'h40, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        #3;
        Rst_n = 1'b0;
        #1;
        n_total++; if (pc !== 32'h0 || ifid_valid !== 1'b0 || flush !== 1'b0 ||
                       ifid_instr !== 32'h0 || ifid_pcp4 !== 32'h0)
            $display("FAIL mid_rst: got pc=%h v=%b f=%b i=%h p4=%h want all 0",
                     pc, ifid_valid, flush, ifid_instr, ifid_pcp4);
        else n_pass++;
        n_total++; if (taken !== 16'h0 || stall !== 16'h0 || s_taken !== 2'd0)
            $display("FAIL mid_rst_cnt: got %0d %0d %0d want 0 0 0", taken, stall, s_taken);
        else n_pass++;
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        set_in(1, 32'h80, 0, 0, 0);
        tick();
        n_total++; if (pc !== 32'h0) $display("FAIL post_rst_boot: got %h want 0", pc); else n_pass++;
        tick();
        n_total++; if (pc !== 32'h80 || flush !== 1'b1)
            $display("FAIL post_rst_br: got pc=%h f=%b want 80 1", pc, flush);
        else n_pass++;
        set_in(0, 0, 0, 0, 0); tick(); tick();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 0, 0, 1);
            tick();
        end
        n_total++; if (s_stall !== 2'd3) $display("FAIL sat_small: got %0d want 3", s_stall);
        else n_pass++;
        n_total++; if (stall !== 16'd5) $display("FAIL sat_big: got %0d want 5", stall); else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom % 8) == 0, $urandom, ($urandom % 8) == 0, $urandom,
                   ($urandom % 4) == 0);
            tick();
            n_total++; if (pc !== m_pc || ifid_instr !== m_instr || ifid_pcp4 !== m_pcp4 ||
                           ifid_valid !== m_valid || flush !== m_flush)
                $display("FAIL rnd_pipe[%0d]: got %h %h %h %b %b want %h %h %h %b %b", k,
                         pc, ifid_instr, ifid_pcp4, ifid_valid, flush,
                         m_pc, m_instr, m_pcp4, m_valid, m_flush);
            else n_pass++;
            n_total++; if (taken !== 16'(sat(m_taken, 65535)) || stall !== 16'(sat(m_stall, 65535)) ||
                           s_taken !== 2'(sat(m_taken, 3)) || s_stall !== 2'(sat(m_stall, 3)))
                $display("FAIL rnd_cnt[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", k,
                         taken, stall, s_taken, s_stall, sat(m_taken, 65535),
                         sat(m_stall, 65535), sat(m_taken, 3), sat(m_stall, 3));
            else n_pass++;
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_boot_fetch();
        test_branch();
        test_shadow();
        test_stall();
        test_jump();
        test_reset_mid_redirect();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
